// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Round-robin arbiter that shares the single-port shared memory among the
//   processors of the pool. At most one registered one-hot grant (read or
//   write) is active in any cycle. A grant is held for the length of a burst,
//   but once it has run for MAX_BURST cycles it is handed over if another
//   port is waiting. This keeps one port from starving the others.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous reset, active-high
//   i_req_rd    per-port read request (level, held until served)
//   i_req_wr    per-port write request (level, held until served)
//   o_grant_rd  one-hot read grant, registered
//   o_grant_wr  one-hot write grant, registered
//   o_sel       index of the granted port; valid while o_busy=1
//   o_busy      any grant active
//
// Configuration macro:
//   ARB_WR_PRIORITY_EN  when defined, any pending write beats every pending
//                       read. Round-robin order applies among writes first,
//                       then among reads. Within a port, write beats read.
//                       An active read grant is pre-empted at MAX_BURST
//                       whenever a write is pending, even from the same port.
//                       When undefined, the arbiter is pure round-robin and
//                       serves a port's read before its write.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int PORT_COUNT = 4,
    parameter int MAX_BURST  = 8,
    parameter int IDX_W      = $clog2(PORT_COUNT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PORT_COUNT-1:0] i_req_rd,
    input  logic [PORT_COUNT-1:0] i_req_wr,
    output logic [PORT_COUNT-1:0] o_grant_rd,
    output logic [PORT_COUNT-1:0] o_grant_wr,
    output logic [IDX_W-1:0]      o_sel,
    output logic                  o_busy
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(PORT_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_RD = 2'd1,
        ST_GRANT_WR = 2'd2
    } state_t;

    state_t                  state;
    logic [PORT_COUNT-1:0]   grant_rd;
    logic [PORT_COUNT-1:0]   grant_wr;
    logic [IDX_W-1:0]        sel;
    logic [IDX_W-1:0]        ptr;
    logic [CNT_W-1:0]        burst_cnt;

    logic [PORT_COUNT-1:0]   cur_mask;
    logic [PORT_COUNT-1:0]   others_req;
    logic                    granted_req;
    logic                    cnt_full;
    logic                    hold;
    logic                    forced;
    logic [PORT_COUNT-1:0]   cand_rd;
    logic [PORT_COUNT-1:0]   cand_wr;
    logic [IDX_W-1:0]        scan_base;
    logic                    win_found;
    logic                    win_is_wr;
    logic [IDX_W-1:0]        win_idx;
`ifdef ARB_WR_PRIORITY_EN
    logic [IDX_W:0]          pick_wr;
    logic [IDX_W:0]          pick_rd;
`else
    logic [IDX_W:0]          pick_any;
`endif

    // Finds the first set bit of vec in round-robin order. The scan starts at
    // (base+1) and wraps, so base itself is checked last. The loop walks from
    // lowest priority to highest, which lets the highest-priority hit
    // overwrite the earlier ones. Result: {found, index}.
    function automatic logic [IDX_W:0] pick_first(
        input logic [PORT_COUNT-1:0] vec,
        input logic [IDX_W-1:0]      base
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] pos_idx;
        int               pos;
        res = '0;
        for (int k = PORT_COUNT; k >= 1; k--) begin
            pos     = (int'(base) + k) % PORT_COUNT;
            pos_idx = pos[IDX_W-1:0];
            if (vec[pos_idx]) begin
                res = {1'b1, pos_idx};
            end
        end
        return res;
    endfunction

    // Decides whether the current grant is held, released or forced to
    // rotate. It then picks the next winner.
    //
    // Once a grant is active, the scan starts just after the holder. So on a
    // release or rotation the holder ends up last in line. This matches the
    // pointer being updated to the holder on that same edge.
    //
    // On a forced rotation the holder's requests are masked out, so it waits
    // one round. One exception applies with write priority enabled: if a read
    // was pre-empted by a write from the same port, that write stays eligible.
    always_comb begin
        cur_mask      = '0;
        cur_mask[sel] = 1'b1;
        others_req    = (i_req_rd | i_req_wr) & ~cur_mask;
        cnt_full      = (burst_cnt == CNT_MAX);

        case (state)
            ST_GRANT_RD: granted_req = i_req_rd[sel];
            ST_GRANT_WR: granted_req = i_req_wr[sel];
            default:     granted_req = 1'b0;
        endcase

`ifdef ARB_WR_PRIORITY_EN
        if (state == ST_GRANT_RD) begin
            hold = granted_req && (!cnt_full || (!(|others_req) && !i_req_wr[sel]));
        end else begin
            hold = granted_req && (!cnt_full || !(|others_req));
        end
`else
        hold = granted_req && (!cnt_full || !(|others_req));
`endif
        forced = granted_req && !hold;

        cand_rd = i_req_rd;
        cand_wr = i_req_wr;
        if (forced) begin
            cand_rd = i_req_rd & ~cur_mask;
`ifdef ARB_WR_PRIORITY_EN
            if (state != ST_GRANT_RD) begin
                cand_wr = i_req_wr & ~cur_mask;
            end
`else
            cand_wr = i_req_wr & ~cur_mask;
`endif
        end

        scan_base = (state == ST_IDLE) ? ptr : sel;

`ifdef ARB_WR_PRIORITY_EN
        pick_wr = pick_first(cand_wr, scan_base);
        pick_rd = pick_first(cand_rd, scan_base);
        if (pick_wr[IDX_W]) begin
            win_found = 1'b1;
            win_is_wr = 1'b1;
            win_idx   = pick_wr[IDX_W-1:0];
        end else begin
            win_found = pick_rd[IDX_W];
            win_is_wr = 1'b0;
            win_idx   = pick_rd[IDX_W-1:0];
        end
`else
        pick_any  = pick_first(cand_rd | cand_wr, scan_base);
        win_found = pick_any[IDX_W];
        win_idx   = pick_any[IDX_W-1:0];
        win_is_wr = !cand_rd[win_idx];
`endif
    end

    // Grant state machine. Grants, sel and the burst counter are all
    // registered together, so o_sel never gets out of step with the grant
    // vectors.
    //
    // While a grant is held, the burst counter counts up and saturates. This
    // lets a port that is alone on the bus keep its grant indefinitely.
    //
    // Any change of owner does three things on one edge: it moves the pointer
    // to the old holder, loads the new winner, and restarts the count at 1.
    // No idle bubble is inserted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            grant_rd  <= '0;
            grant_wr  <= '0;
            sel       <= '0;
            ptr       <= PTR_RESET;
            burst_cnt <= '0;
        end else if (hold) begin
            if (!cnt_full) begin
                burst_cnt <= burst_cnt + CNT_ONE;
            end
        end else begin
            if (state != ST_IDLE) begin
                ptr <= sel;
            end
            if (win_found) begin
                sel       <= win_idx;
                burst_cnt <= CNT_ONE;
                grant_rd  <= '0;
                grant_wr  <= '0;
                if (win_is_wr) begin
                    state             <= ST_GRANT_WR;
                    grant_wr[win_idx] <= 1'b1;
                end else begin
                    state             <= ST_GRANT_RD;
                    grant_rd[win_idx] <= 1'b1;
                end
            end else begin
                state     <= ST_IDLE;
                grant_rd  <= '0;
                grant_wr  <= '0;
                burst_cnt <= '0;
            end
        end
    end

    assign o_grant_rd = grant_rd;
    assign o_grant_wr = grant_wr;
    assign o_sel      = sel;
    assign o_busy     = (|grant_rd) | (|grant_wr);

endmodule
